mul8_sequencer: RTL and testbench
=================================

Name: mul8_sequencer

Overview:
Multi-cycle controller that computes an unsigned 8x8 -> 16-bit product by time-sharing one Four_Bit_Multiplier instance over four partial-product steps. It latches operands on a start handshake and sequences nibble pairs into the shared 4x4 multiplier. It shifts and accumulates the 8-bit results and signals completion. It sits between the Fixed_Point_ALU opcode decoder and the existing combinational 4-bit multiplier. The multiplier is instantiated at ALU top level and wired to this block's mul_* ports.

Parameters:
DONE_HOLD, 0, 0: done is a 1-cycle pulse; 1: done holds high until the next accepted start or abort.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted when start=1 and ready=1
abort  input  1  synchronous cancel of an operation in progress
a  input  8  multiplicand, sampled on accept
b  input  8  multiplier, sampled on accept
ready  output  1  high in IDLE and DONE states
busy  output  1  high in MUL state
done  output  1  completion flag; product valid while high
product  output  16  result, registered
mul_a  output  4  nibble to shared multiplier input A
mul_b  output  4  nibble to shared multiplier input B
mul_out  input  8  combinational product returned from the shared multiplier

Behaviour:
- Reset (rst_n=0, async): state=IDLE, step=0, operand regs=0, acc=0, product=0, done=0, busy=0, ready=1. mul_a and mul_b drive 0 in IDLE and DONE.
- States: IDLE, MUL, DONE; step counter is 2 bits.
- IDLE: on accept, latch a and b, clear acc, step<=0, go to MUL.
- MUL, one step per cycle. mul_a and mul_b are combinational from the latched operands and step:
  - step0: aL*bL, added to acc at shift 0
  - step1: aL*bH, added at shift 4
  - step2: aH*bL, added at shift 4
  - step3: aH*bH, added at shift 8
  - acc<=acc+({8'b0,mul_out}<<shift), 16-bit arithmetic. No overflow is possible because max 0xFF*0xFF=0xFE01.
  - After step3: product<=final sum, done<=1, go to DONE.
- Latency: accept at edge N; steps at edges N+1..N+4. done and the new product are visible after edge N+4, i.e. 4 cycles after the accept edge.
- DONE:
  - DONE_HOLD=0: done is high for exactly one cycle.
  - DONE_HOLD=1: done stays high until the next accept or abort.
  - ready=1 in DONE, so start accepted in DONE begins a new operation immediately (back-to-back throughput of 1 result per 5 cycles). done deasserts on that accept edge.
  - Without start, DONE returns to IDLE the following cycle (DONE_HOLD=0) or stays (DONE_HOLD=1).
- product holds its last value until overwritten at the end of the next completed operation. It is not cleared on accept.
- start while busy: ignored; operands are not re-sampled.
- abort:
  - In MUL: go to IDLE, step<=0, no done, product unchanged.
  - In DONE: clears done and goes to IDLE.
  - abort and start in the same cycle: abort wins; start is not accepted.
- Async reset mid-operation: immediate return to the reset values above. No done is issued.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants (IDLE, MUL, DONE)
  - step index constants
  - shift amount constants SH0=0, SH4=4, SH8=8
  - widths NIB_W=4, OP_W=8, RES_W=16
- One natural sub-module, pp_align: takes step and mul_out and returns the zero-extended, shifted 16-bit partial product. The FSM, counter and accumulator stay in mul8_sequencer.

Test Plan:
- Reset, then a=0x12, b=0x34, start for 1 cycle -> mul_a/mul_b sequence (2,4),(2,3),(1,4),(1,3); done pulses 4 cycles after the accept edge; product=0x03A8.
- a=0xFF, b=0xFF -> product=0xFE01. Then a=0x00, b=0xAB -> product=0x0000; done pulses once each run.
- Back-to-back: hold start high with new operands 0x0F*0x10 in the DONE cycle -> accepted that cycle; second done 5 cycles after the first; product=0x00F0.
- start pulsed at steps 1 and 2 of a busy run with different a/b -> ignored; result equals the first operands' product. abort at step 2 -> IDLE, no done, product keeps its previous value.
- Assert rst_n=0 asynchronously at step 1 -> outputs return to reset values immediately. Next run 0x07*0x09 -> product=0x003F.
- DONE_HOLD=1 build: run 0x20*0x03 -> done stays high with product=0x0060 until the next start or abort, then drops on that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the sequenced 8x8 multiplier.
package alu_pkg;

    // Datapath widths: nibble, operand and full product.
    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    // Partial-product step indices.
    localparam logic [1:0] STEP0 = 2'd0;  // aL * bL
    localparam logic [1:0] STEP1 = 2'd1;  // aL * bH
    localparam logic [1:0] STEP2 = 2'd2;  // aH * bL
    localparam logic [1:0] STEP3 = 2'd3;  // aH * bH

    // Alignment of each partial product inside the 16-bit accumulator.
    localparam int unsigned SH0 = 0;
    localparam int unsigned SH4 = 4;
    localparam int unsigned SH8 = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/pp_align.sv
// Zero-extends the shared 4x4 multiplier result and shifts it into place for the current step.
module pp_align
    import alu_pkg::*;
(
    input  logic [1:0]       step,
    input  logic [OP_W-1:0]  mul_out,
    output logic [RES_W-1:0] pp
);

    logic [RES_W-1:0] ext;

    assign ext = {{(RES_W - OP_W){1'b0}}, mul_out};

    // Select the shift for the nibble pair being multiplied this cycle.
    always_comb begin
        pp = ext;
        unique case (step)
            STEP0:        pp = ext << SH0;
            STEP1, STEP2: pp = ext << SH4;
            STEP3:        pp = ext << SH8;
            default:      pp = ext;
        endcase
    end

endmodule

// File: rtl/mul8_sequencer.sv
// Multi-cycle 8x8 -> 16 unsigned multiplier built around one shared external 4x4 multiplier.
// Four partial products are accumulated over four MUL cycles; done marks a valid product.
module mul8_sequencer
    import alu_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] product,
    output logic [NIB_W-1:0] mul_a,
    output logic [NIB_W-1:0] mul_b,
    input  logic [OP_W-1:0]  mul_out
);

    state_t           state_q;
    logic [1:0]       step_q;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] pp;
    logic [RES_W-1:0] sum;
    logic             accept;

    // A request is taken only when idle/done and not overridden by abort.
    assign accept = start && ready && !abort;

    // Step bit 1 picks the high nibble of a, step bit 0 the high nibble of b.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == StMul) begin
            mul_a = step_q[1] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
            mul_b = step_q[0] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
        end
    end

    pp_align u_pp_align (
        .step    (step_q),
        .mul_out (mul_out),
        .pp      (pp)
    );

    assign sum = acc_q + pp;

    // Control FSM, step counter, accumulator and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= STEP0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        step_q  <= STEP0;
                        state_q <= StMul;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                StMul: begin
                    if (abort) begin
                        step_q  <= STEP0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        acc_q  <= sum;
                        step_q <= step_q + 2'd1;
                        if (step_q == STEP3) begin
                            product <= sum;
                            done    <= 1'b1;
                            state_q <= StDone;
                            busy    <= 1'b0;
                            ready   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (abort) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end else if (accept) begin
                        // Back-to-back: start the next operation straight from DONE.
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        step_q  <= STEP0;
                        done    <= 1'b0;
                        state_q <= StMul;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end else if (!DONE_HOLD) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_sequencer.sv
// Bench for mul8_sequencer: instance 0 with DONE_HOLD=0, instance 1 with DONE_HOLD=1.
module tb_mul8_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic       abort_v [2];
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic       ready_v [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic [15:0] prod_v [2];
    logic [3:0] ma_v [2];
    logic [3:0] mb_v [2];
    logic [7:0] mo_v [2];

    int n_test = 0;
    int n_fail = 0;
    int n_done0 = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared 4x4 multiplier.
    assign mo_v[0] = {4'b0, ma_v[0]} * {4'b0, mb_v[0]};
    assign mo_v[1] = {4'b0, ma_v[1]} * {4'b0, mb_v[1]};

    mul8_sequencer #(.DONE_HOLD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .a(a_v[0]), .b(b_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .product(prod_v[0]), .mul_a(ma_v[0]), .mul_b(mb_v[0]), .mul_out(mo_v[0])
    );

    mul8_sequencer #(.DONE_HOLD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .a(a_v[1]), .b(b_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .product(prod_v[1]), .mul_a(ma_v[1]), .mul_b(mb_v[1]), .mul_out(mo_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is "running" for 4 cycles with a cycle index; the product is a*b.
    bit        m_run [2]  = '{1'b0, 1'b0};
    int        m_cnt [2]  = '{0, 0};
    bit        m_done [2] = '{1'b0, 1'b0};
    int        m_prod [2] = '{0, 0};
    int        m_a [2]    = '{0, 0};
    int        m_b [2]    = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i] = 1'b0; m_cnt[i] = 0; m_done[i] = 1'b0; m_prod[i] = 0;
            end else if (m_run[i]) begin
                if (abort_v[i]) begin
                    m_run[i] = 1'b0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == 4) begin
                        m_run[i]  = 1'b0;
                        m_done[i] = 1'b1;
                        m_prod[i] = m_a[i] * m_b[i];
                    end
                end
            end else begin
                if (abort_v[i]) begin
                    m_done[i] = 1'b0;
                end else if (start_v[i]) begin
                    m_run[i] = 1'b1; m_cnt[i] = 0; m_done[i] = 1'b0;
                    m_a[i] = int'(a_v[i]); m_b[i] = int'(b_v[i]);
                end else if (i == 0) begin
                    m_done[i] = 1'b0;
                end
            end
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int ea, eb;
                ea = 0; eb = 0;
                if (m_run[i]) begin
                    ea = (m_cnt[i] >= 2) ? (m_a[i] >> 4) : (m_a[i] & 15);
                    eb = (m_cnt[i] % 2 == 1) ? (m_b[i] >> 4) : (m_b[i] & 15);
                end
                chk($sformatf("ready%0d", i), 32'(ready_v[i]), 32'(!m_run[i]));
                chk($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_run[i]));
                chk($sformatf("done%0d", i), 32'(done_v[i]), 32'(m_done[i]));
                chk($sformatf("product%0d", i), 32'(prod_v[i]), 32'(m_prod[i]));
                chk($sformatf("mul_a%0d", i), 32'(ma_v[i]), 32'(ea));
                chk($sformatf("mul_b%0d", i), 32'(mb_v[i]), 32'(eb));
            end
        end
        if (done_v[0] === 1'b1) n_done0++;
    end

    task automatic set_in(input int i, input bit s, input bit ab, input logic [7:0] av,
                          input logic [7:0] bv);
        start_v[i] = s; abort_v[i] = ab; a_v[i] = av; b_v[i] = bv;
    endtask

    // Pulse start for one cycle; returns at the first negedge after the accept edge.
    task automatic launch(input int i, input logic [7:0] av, input logic [7:0] bv);
        set_in(i, 1'b1, 1'b0, av, bv);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int k);
        k = 0;
        while (done_v[i] !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        if (k >= 12) begin
            n_test++; n_fail++;
            $display("FAIL done_timeout%0d: no done within 12 cycles", i);
        end
    endtask

    initial begin
        int k;
        int d0;
        logic [3:0] exp_ma [4];
        logic [3:0] exp_mb [4];
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_v[0]), 32'd1);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_product", 32'(prod_v[0]), 32'h0);
        chk("rst_mul_a", 32'(ma_v[0]), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 0x12 * 0x34: nibble sequence and done 4 cycles after accept.
        exp_ma = '{4'd2, 4'd2, 4'd1, 4'd1};
        exp_mb = '{4'd4, 4'd3, 4'd4, 4'd3};
        launch(0, 8'h12, 8'h34);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("seq_mul_a%0d", s), 32'(ma_v[0]), 32'(exp_ma[s]));
            chk($sformatf("seq_mul_b%0d", s), 32'(mb_v[0]), 32'(exp_mb[s]));
            chk($sformatf("seq_done%0d", s), 32'(done_v[0]), 32'd0);
            @(negedge clk);
        end
        chk("t1_done", 32'(done_v[0]), 32'd1);
        chk("t1_product", 32'(prod_v[0]), 32'h03A8);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done_v[0]), 32'd0);

        // Extremes: full-scale and zero operand, exactly one done each.
        d0 = n_done0;
        launch(0, 8'hFF, 8'hFF);
        wait_done(0, k);
        chk("ff_latency", 32'(k), 32'd4);
        chk("ff_product", 32'(prod_v[0]), 32'hFE01);
        @(negedge clk);
        launch(0, 8'h00, 8'hAB);
        wait_done(0, k);
        chk("zero_product", 32'(prod_v[0]), 32'h0000);
        repeat (2) @(negedge clk);
        chk("done_count", 32'(n_done0 - d0), 32'd2);

        // Back-to-back: start held in the DONE cycle is accepted immediately.
        launch(0, 8'h02, 8'h03);
        wait_done(0, k);
        chk("b2b_first", 32'(prod_v[0]), 32'h0006);
        set_in(0, 1'b1, 1'b0, 8'h0F, 8'h10);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_done_drop", 32'(done_v[0]), 32'd0);
        wait_done(0, k);
        chk("b2b_gap", 32'(k + 1), 32'd5);
        chk("b2b_product", 32'(prod_v[0]), 32'h00F0);
        @(negedge clk);

        // Start while busy is ignored.
        launch(0, 8'h56, 8'h78);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 8'h99, 8'h11);
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, k);
        chk("ignore_product", 32'(prod_v[0]), 32'h2850);
        @(negedge clk);

        // Abort at step 2 (start asserted alongside): back to idle, product kept.
        d0 = n_done0;
        launch(0, 8'h33, 8'h44);
        repeat (2) @(negedge clk);
        set_in(0, 1'b1, 1'b1, 8'h44, 8'h55);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_ready", 32'(ready_v[0]), 32'd1);
        chk("abort_product", 32'(prod_v[0]), 32'h2850);
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(n_done0 - d0), 32'd0);

        // Abort and start together in idle: abort wins.
        set_in(0, 1'b1, 1'b1, 8'h12, 8'h12);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("abort_wins", 32'(busy_v[0]), 32'd0);

        // Asynchronous reset at step 1.
        launch(0, 8'hAA, 8'hBB);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_v[0]), 32'd1);
        chk("arst_busy", 32'(busy_v[0]), 32'd0);
        chk("arst_done", 32'(done_v[0]), 32'd0);
        chk("arst_product", 32'(prod_v[0]), 32'h0);
        chk("arst_mul_a", 32'(ma_v[0]), 32'd0);
        chk("arst_mul_b", 32'(mb_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(0, 8'h07, 8'h09);
        wait_done(0, k);
        chk("post_rst_product", 32'(prod_v[0]), 32'h003F);
        @(negedge clk);

        // DONE_HOLD=1: done held until next accept, then until abort.
        launch(1, 8'h20, 8'h03);
        wait_done(1, k);
        chk("hold_latency", 32'(k), 32'd4);
        chk("hold_product", 32'(prod_v[1]), 32'h0060);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk($sformatf("hold_done%0d", s), 32'(done_v[1]), 32'd1);
        end
        launch(1, 8'h05, 8'h05);
        chk("hold_drop_start", 32'(done_v[1]), 32'd0);
        wait_done(1, k);
        chk("hold_product2", 32'(prod_v[1]), 32'h0019);
        repeat (2) @(negedge clk);
        chk("hold_still", 32'(done_v[1]), 32'd1);
        set_in(1, 1'b0, 1'b1, 8'h00, 8'h00);
        @(negedge clk);
        abort_v[1] = 1'b0;
        chk("hold_drop_abort", 32'(done_v[1]), 32'd0);
        chk("hold_keep_product", 32'(prod_v[1]), 32'h0019);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
